atm_message_sequencer: RTL and testbench
========================================

ATM_MESSAGE_SEQUENCER -- requirements
Module: atm_message_sequencer

Interface
REQ-001 Parameter CHAR_W, default 5, SHALL set the bits per display character code.
REQ-002 Parameter DISP_CHARS, default 8, SHALL set the number of display character positions.
REQ-003 Parameter N_CURRENCY, default 5, SHALL set the selectable currencies: 0=DOLLAR, 1=BTC, 2=ETH, 3=XRP, 4=LTC, then further entries.
REQ-004 Parameter BLINK_DIV, default 50_000_000, SHALL set the clk cycles per blink half-period.
REQ-005 Parameter SCROLL_DIV, default 25_000_000, SHALL set the clk cycles per scroll step.
REQ-006 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-008 states  input  4  SHALL carry the ATM top-level state code.
REQ-009 btn_up  input  1  SHALL be a debounced level; each rising edge requests next currency.
REQ-010 btn_down  input  1  SHALL be a debounced level; each rising edge requests previous currency.
REQ-011 instruction  output  CHAR_W*DISP_CHARS  SHALL carry the registered message; char 0 is in the LSBs.
REQ-012 currency_sel  output  $clog2(N_CURRENCY)  SHALL carry the current currency index.
REQ-013 sel_changed  output  1  SHALL be a one-cycle pulse when currency_sel changes.

Function
REQ-014 Button edges SHALL be detected by registering each button input once and comparing, so an edge is acted on one cycle after the input rises.
REQ-015 currency_sel SHALL change only while states is 4'b0110 (deposit) or 4'b1011 (withdraw); edges in other states SHALL be discarded.
REQ-016 An up edge SHALL increment currency_sel and wrap from N_CURRENCY-1 to 0; a down edge SHALL decrement it and wrap from 0 to N_CURRENCY-1.
REQ-017 Simultaneous up and down edges SHALL leave currency_sel unchanged with no sel_changed pulse.
REQ-018 Entering states 4'b0000 (idle) SHALL force currency_sel to 0 on the next cycle; if currency_sel was nonzero, sel_changed SHALL pulse.
REQ-019 instruction SHALL be registered with one cycle of latency from states or currency_sel.
REQ-020 Message per state:
- 0000 -> WELCOME
- 0110/1011 -> name of the selected currency
- 1101 -> ERROR
- 1110 -> SUCCESS
- any other code -> BLANK (all positions the BLANK char code)
REQ-021 The display FSM SHALL have states SHOW, BLINK_OFF, SCROLL.
REQ-022 In state 1101 the FSM SHALL alternate SHOW/BLINK_OFF every BLINK_DIV cycles; BLINK_OFF outputs BLANK.
REQ-023 The blink counter SHALL restart from zero in SHOW on every entry to state 1101.
REQ-024 Any change of states SHALL return the FSM to SHOW (or SCROLL per REQ-028) within one cycle.
REQ-025 Counters SHALL be sized $clog2 of their divider and SHALL wrap to 0 after reaching divider-1.

Reset
REQ-026 While rst is high:
- instruction = BLANK
- currency_sel = 0
- sel_changed = 0
- FSM = SHOW
- all counters and edge registers = 0
REQ-027 A reset asserted mid-blink or mid-scroll SHALL take effect immediately; the first post-reset message SHALL follow REQ-019.

Configuration
REQ-028 With macro ATM_MSG_SCROLL_EN defined:
- idle SHALL use a 16-char WELCOME TO ATM message in FSM state SCROLL
- the window SHALL advance one char every SCROLL_DIV cycles, wrapping circularly
- the window SHALL restart at offset 0 on idle entry
REQ-029 Without ATM_MSG_SCROLL_EN, the SCROLL state and scroll counter SHALL not exist, and idle SHALL show the static 8-char WELCOME.

Structure
REQ-030 Package atm_msg_pkg SHALL hold:
- state code constants (IDLE, DEPOSIT, WITHDRAW, ERROR, SUCCESS)
- the character code typedef
- BLANK
- all message constants
- the currency-name table
REQ-031 Sub-module atm_msg_rom (combinational: state, currency index, scroll offset -> message) SHALL be instantiated once; the sequencer adds only the registers.

Verification
REQ-032 Scenario: rst=1, then states=0000 -> instruction=WELCOME one cycle after release, currency_sel=0.
REQ-033 Scenario: states=0110 with six btn_up pulses -> currency_sel 1,2,3,4,0,1; sel_changed pulses six times; instruction=BTC last.
REQ-034 Scenario: states=1011, sel=0, one btn_down pulse -> currency_sel=4 (LTC); then both buttons rise on the same cycle -> no change, no pulse.
REQ-035 Scenario: states=1101 with BLINK_DIV=4 -> instruction ERROR for 4 cycles, BLANK for 4, repeating; switching to 1110 mid-BLANK -> SUCCESS next cycle.
REQ-036 Scenario: states=0000 after sel=3 -> currency_sel=0 and sel_changed pulse; btn_up in idle is ignored.
REQ-037 Scenario: ATM_MSG_SCROLL_EN defined, SCROLL_DIV=2 -> window offset advances every 2 cycles and wraps from 15 to 0; rst asserted mid-scroll -> BLANK immediately.

Source files
------------

// File: rtl/atm_msg_pkg.sv
// atm_msg_pkg: state codes, display character encoding and message constants
// shared by the ATM message sequencer and its message ROM.
// Character code: 'A'..'Z' -> 0..25, BLANK -> 31.
package atm_msg_pkg;

  localparam logic [3:0] ST_IDLE     = 4'b0000;
  localparam logic [3:0] ST_DEPOSIT  = 4'b0110;
  localparam logic [3:0] ST_WITHDRAW = 4'b1011;
  localparam logic [3:0] ST_ERROR    = 4'b1101;
  localparam logic [3:0] ST_SUCCESS  = 4'b1110;

  localparam int CHAR_BITS = 5;
  typedef logic [CHAR_BITS-1:0] char_t;
  localparam char_t BLANK = 5'd31;

  typedef char_t [7:0]  msg8_t;   // char 0 is displayed leftmost
  typedef char_t [15:0] msg16_t;

  typedef enum logic [1:0] {
    D_SHOW,
    D_BLINK_OFF
`ifdef ATM_MSG_SCROLL_EN
    , D_SCROLL
`endif
  } disp_state_t;

  // ASCII letter to display code; anything else shows as BLANK
  function automatic char_t asc2chr(input logic [7:0] a);
    if (a >= 8'h41 && a <= 8'h5A) return char_t'(a - 8'h41);
    return BLANK;
  endfunction

  // String literals put the first character in the top byte
  function automatic msg8_t pack8(input logic [63:0] s);
    msg8_t m;
    for (int i = 0; i < 8; i++) m[i] = asc2chr(s[(7-i)*8 +: 8]);
    return m;
  endfunction

  function automatic msg16_t pack16(input logic [127:0] s);
    msg16_t m;
    for (int i = 0; i < 16; i++) m[i] = asc2chr(s[(15-i)*8 +: 8]);
    return m;
  endfunction

  localparam msg8_t  MSG_BLANK   = {8{BLANK}};
  localparam msg8_t  MSG_WELCOME = pack8("WELCOME ");
  localparam msg8_t  MSG_ERROR   = pack8("ERROR   ");
  localparam msg8_t  MSG_SUCCESS = pack8("SUCCESS ");
  localparam msg16_t MSG_SCROLL  = pack16("WELCOME TO ATM  ");

  // Named currencies; indices beyond the table display BLANK
  localparam int N_CUR_NAMES = 5;
  localparam msg8_t CUR_NAMES [N_CUR_NAMES] = '{
    pack8("DOLLAR  "), pack8("BTC     "), pack8("ETH     "),
    pack8("XRP     "), pack8("LTC     ")
  };

endpackage

// File: rtl/atm_msg_rom.sv
// atm_msg_rom: combinational message lookup (state, currency, scroll offset).
// Optional: ATM_MSG_SCROLL_EN adds the offset port and the scrolling idle banner.
module atm_msg_rom
  import atm_msg_pkg::*;
#(
  parameter int CHAR_W     = 5,
  parameter int DISP_CHARS = 8,
  parameter int SEL_W      = 3
) (
  input  logic [3:0]                         states,
  input  logic [SEL_W-1:0]                   currency_sel,
`ifdef ATM_MSG_SCROLL_EN
  input  logic [3:0]                         offset,
`endif
  output logic [DISP_CHARS-1:0][CHAR_W-1:0]  msg
);

  msg8_t base;

  // Pick the 8-char message for the current ATM state
  always_comb begin
    base = MSG_BLANK;
    case (states)
`ifdef ATM_MSG_SCROLL_EN
      ST_IDLE: begin
        for (int i = 0; i < 8; i++) base[i] = MSG_SCROLL[offset + 4'(i)];
      end
`else
      ST_IDLE:                 base = MSG_WELCOME;
`endif
      ST_DEPOSIT, ST_WITHDRAW: if (int'(currency_sel) < N_CUR_NAMES)
                                 base = CUR_NAMES[3'(currency_sel)];
      ST_ERROR:                base = MSG_ERROR;
      ST_SUCCESS:              base = MSG_SUCCESS;
      default:                 base = MSG_BLANK;
    endcase
  end

  // Fit the 8-char message onto the display; extra positions stay blank
  for (genvar p = 0; p < DISP_CHARS; p++) begin : g_pos
    if (p < 8) begin : g_msg
      assign msg[p] = CHAR_W'(base[p]);
    end else begin : g_pad
      assign msg[p] = CHAR_W'(BLANK);
    end
  end

endmodule

// File: rtl/atm_message_sequencer.sv
// atm_message_sequencer: currency selection from button edges and the
// registered display message with ERROR blinking.
// Optional: define ATM_MSG_SCROLL_EN for the scrolling 16-char idle banner.
module atm_message_sequencer
  import atm_msg_pkg::*;
#(
  parameter int CHAR_W     = 5,
  parameter int DISP_CHARS = 8,
  parameter int N_CURRENCY = 5,
  parameter int BLINK_DIV  = 50_000_000,
  parameter int SCROLL_DIV = 25_000_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3:0]                      states,
  input  logic                            btn_up,
  input  logic                            btn_down,
  output logic [CHAR_W*DISP_CHARS-1:0]    instruction,
  output logic [$clog2(N_CURRENCY)-1:0]   currency_sel,
  output logic                            sel_changed
);

  localparam int SEL_W = $clog2(N_CURRENCY);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(N_CURRENCY - 1);
  localparam logic [BW-1:0]    BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [DISP_CHARS-1:0][CHAR_W-1:0] BLANK_LINE = {DISP_CHARS{CHAR_W'(BLANK)}};

  if (N_CURRENCY < 2 || BLINK_DIV < 1 || SCROLL_DIV < 1) begin : g_bad_cfg
    $error("atm_message_sequencer: N_CURRENCY >= 2 and dividers >= 1 required");
  end

  logic                               up_q, dn_q, up_e, dn_e, sel_mode, fresh;
  logic [SEL_W-1:0]                   sel_nxt;
  logic [3:0]                         states_q;
  disp_state_t                        dst, dst_nxt, cur;
  logic [BW-1:0]                      blk_cnt, blk_cur, blk_nxt;
  logic [3:0]                         off_cur;
  logic [DISP_CHARS-1:0][CHAR_W-1:0]  rom_msg, instr_nxt;
`ifdef ATM_MSG_SCROLL_EN
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);
  logic [SW-1:0] scr_cnt, scr_cur, scr_nxt;
  logic [3:0]    off, off_nxt;
`endif

  assign up_e     = btn_up & ~up_q;
  assign dn_e     = btn_down & ~dn_q;
  assign sel_mode = (states == ST_DEPOSIT) || (states == ST_WITHDRAW);
  assign fresh    = (states != states_q);

  // Next currency index: idle clears, opposing edges cancel
  always_comb begin
    sel_nxt = currency_sel;
    if (states == ST_IDLE)
      sel_nxt = '0;
    else if (sel_mode && up_e && !dn_e)
      sel_nxt = (currency_sel == SEL_MAX) ? '0 : currency_sel + SEL_W'(1);
    else if (sel_mode && dn_e && !up_e)
      sel_nxt = (currency_sel == '0) ? SEL_MAX : currency_sel - SEL_W'(1);
  end

  // Button edge registers and currency selection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q         <= 1'b0;
      dn_q         <= 1'b0;
      currency_sel <= '0;
      sel_changed  <= 1'b0;
    end else begin
      up_q         <= btn_up;
      dn_q         <= btn_down;
      currency_sel <= sel_nxt;
      sel_changed  <= (sel_nxt != currency_sel);
    end
  end

  // Display FSM state register, blink/scroll counters, last seen ATM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst      <= D_SHOW;
      blk_cnt  <= '0;
      states_q <= ST_IDLE;
`ifdef ATM_MSG_SCROLL_EN
      scr_cnt  <= '0;
      off      <= '0;
`endif
    end else begin
      dst      <= dst_nxt;
      blk_cnt  <= blk_nxt;
      states_q <= states;
`ifdef ATM_MSG_SCROLL_EN
      scr_cnt  <= scr_nxt;
      off      <= off_nxt;
`endif
    end
  end

  // Next-state: a change of ATM state behaves as a fresh entry this cycle,
  // so the message reacts immediately and counters restart from zero.
  always_comb begin
    cur     = D_SHOW;
    dst_nxt = D_SHOW;
    blk_cur = '0;
    blk_nxt = '0;
    off_cur = '0;
`ifdef ATM_MSG_SCROLL_EN
    scr_cur = '0;
    scr_nxt = '0;
    off_nxt = '0;
`endif
    if (states == ST_ERROR) begin
      if (!fresh) begin
        cur     = dst;
        blk_cur = blk_cnt;
      end
      dst_nxt = cur;
      if (blk_cur == BLK_LAST) begin
        blk_nxt = '0;
        dst_nxt = (cur == D_SHOW) ? D_BLINK_OFF : D_SHOW;
      end else begin
        blk_nxt = blk_cur + BW'(1);
      end
    end
`ifdef ATM_MSG_SCROLL_EN
    else if (states == ST_IDLE) begin
      cur     = D_SCROLL;
      dst_nxt = D_SCROLL;
      if (!fresh) begin
        scr_cur = scr_cnt;
        off_cur = off;
      end
      scr_nxt = (scr_cur == SCR_LAST) ? '0 : scr_cur + SW'(1);
      off_nxt = (scr_cur == SCR_LAST) ? off_cur + 4'd1 : off_cur;
    end
`endif
  end

  atm_msg_rom #(
    .CHAR_W     (CHAR_W),
    .DISP_CHARS (DISP_CHARS),
    .SEL_W      (SEL_W)
  ) u_rom (
    .states       (states),
    .currency_sel (currency_sel),
`ifdef ATM_MSG_SCROLL_EN
    .offset       (off_cur),
`endif
    .msg          (rom_msg)
  );

`ifndef ATM_MSG_SCROLL_EN
  logic unused_off;
  assign unused_off = ^off_cur;
`endif

  // Output: blink-off phase blanks the display, otherwise the ROM message
  always_comb begin
    instr_nxt = rom_msg;
    if (cur == D_BLINK_OFF) instr_nxt = BLANK_LINE;
  end

  // Registered message
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instruction <= BLANK_LINE;
    else     instruction <= instr_nxt;
  end

endmodule

// File: tb/tb_atm_message_sequencer.sv
// tb_atm_message_sequencer: directed scenarios plus randomized states/buttons
// against a cycle-level reference model built from message strings.
module tb_atm_message_sequencer;

  localparam int BDIV = 4;
  localparam int SDIV = 2;
  localparam int NCUR = 5;
  localparam logic [39:0] BLANK_W = {8{5'd31}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  states = 4'b0000;
  logic        btn_up = 1'b0, btn_down = 1'b0;
  logic [39:0] instruction;
  logic [2:0]  currency_sel;
  logic        sel_changed;

  atm_message_sequencer #(
    .CHAR_W(5), .DISP_CHARS(8), .N_CURRENCY(NCUR), .BLINK_DIV(BDIV), .SCROLL_DIV(SDIV)
  ) dut (
    .clk(clk), .rst(rst), .states(states), .btn_up(btn_up), .btn_down(btn_down),
    .instruction(instruction), .currency_sel(currency_sel), .sel_changed(sel_changed)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // 8-char window of s starting at off (circular); ' ' is BLANK, letters A=0
  function automatic logic [39:0] enc(input string s, input int off);
    logic [39:0] r;
    byte c;
    for (int i = 0; i < 8; i++) begin
      c = s[(off + i) % s.len()];
      r[i*5 +: 5] = (c == " ") ? 5'd31 : 5'(c - "A");
    end
    return r;
  endfunction

  string names [NCUR] = '{"DOLLAR  ", "BTC     ", "ETH     ", "XRP     ", "LTC     "};
  string scroll_txt = "WELCOME TO ATM  ";

  // reference model state
  int          m_sel, m_age, exp_sel, pulses;
  logic        m_up, m_dn, exp_chg;
  logic [3:0]  m_st;
  logic [39:0] exp_instr;

  task automatic model_reset();
    m_sel = 0; m_age = -1; m_up = 0; m_dn = 0; m_st = 4'b0000;
    exp_sel = 0; exp_chg = 0; exp_instr = BLANK_W;
  endtask

  // What the registers should hold after the coming rising edge
  task automatic model_step();
    logic ue, de;
    int   old;
    ue = btn_up && !m_up;
    de = btn_down && !m_dn;
    if (states != m_st) m_age = 0; else m_age++;
    case (states)
`ifdef ATM_MSG_SCROLL_EN
      4'b0000: exp_instr = enc(scroll_txt, (m_age / SDIV) % 16);
`else
      4'b0000: exp_instr = enc("WELCOME ", 0);
`endif
      4'b0110, 4'b1011: exp_instr = enc(names[m_sel], 0);
      4'b1101: exp_instr = ((m_age / BDIV) % 2 == 0) ? enc("ERROR   ", 0) : BLANK_W;
      4'b1110: exp_instr = enc("SUCCESS ", 0);
      default: exp_instr = BLANK_W;
    endcase
    old = m_sel;
    if (states == 4'b0000) m_sel = 0;
    else if ((states == 4'b0110 || states == 4'b1011) && (ue != de))
      m_sel = ue ? (m_sel + 1) % NCUR : (m_sel + NCUR - 1) % NCUR;
    exp_sel = m_sel;
    exp_chg = (m_sel != old);
    m_up = btn_up; m_dn = btn_down; m_st = states;
  endtask

  // One clock: drive at negedge, step model, compare at next negedge
  task automatic cyc(input logic [3:0] st, input logic up, input logic dn);
    states = st; btn_up = up; btn_down = dn;
    model_step();
    @(negedge clk);
    if (sel_changed) pulses++;
    chk("instr", 64'(instruction), 64'(exp_instr));
    chk("sel", 64'(currency_sel), 64'(exp_sel));
    chk("chg", 64'(sel_changed), 64'(exp_chg));
  endtask

  initial begin
    logic [3:0] st;
    logic       u, d;
    int         len;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_instr", 64'(instruction), 64'(BLANK_W));
    chk("rst_sel", 64'(currency_sel), 64'd0);
    chk("rst_chg", 64'(sel_changed), 64'd0);
    rst = 1'b0;
    cyc(4'b0000, 0, 0);
    chk("welcome", 64'(instruction), 64'(enc("WELCOME ", 0)));

    // six up pulses in deposit
    cyc(4'b0110, 0, 0);
    pulses = 0;
    repeat (6) begin cyc(4'b0110, 1, 0); cyc(4'b0110, 0, 0); end
    chk("up_pulses", 64'(pulses), 64'd6);
    chk("up_sel", 64'(currency_sel), 64'd1);
    chk("up_btc", 64'(instruction), 64'(enc("BTC     ", 0)));

    // withdraw: down wraps to LTC, simultaneous edges cancel
    cyc(4'b0000, 0, 0);
    cyc(4'b1011, 0, 0);
    cyc(4'b1011, 0, 1); cyc(4'b1011, 0, 0);
    chk("dn_wrap", 64'(currency_sel), 64'd4);
    chk("ltc", 64'(instruction), 64'(enc("LTC     ", 0)));
    pulses = 0;
    cyc(4'b1011, 1, 1); cyc(4'b1011, 0, 0);
    chk("both_sel", 64'(currency_sel), 64'd4);
    chk("both_nopulse", 64'(pulses), 64'd0);

    // idle clears selection from 3 and ignores buttons
    cyc(4'b1011, 0, 1); cyc(4'b1011, 0, 0);
    chk("sel3", 64'(currency_sel), 64'd3);
    cyc(4'b0000, 0, 0);
    chk("idle_clr", 64'(currency_sel), 64'd0);
    chk("idle_pulse", 64'(sel_changed), 64'd1);
    cyc(4'b0000, 1, 0); cyc(4'b0000, 0, 0);
    chk("idle_ign", 64'(currency_sel), 64'd0);

    // ERROR blinks 4 on / 4 off; SUCCESS takes over mid-blank
    for (int k = 0; k < 14; k++) begin
      cyc(4'b1101, 0, 0);
      chk("blink", 64'(instruction),
          64'(((k / BDIV) % 2 == 0) ? enc("ERROR   ", 0) : BLANK_W));
    end
    cyc(4'b1110, 0, 0);
    chk("succ", 64'(instruction), 64'(enc("SUCCESS ", 0)));
    cyc(4'b1101, 0, 0);
    chk("err_restart", 64'(instruction), 64'(enc("ERROR   ", 0)));
    repeat (5) cyc(4'b1101, 0, 0);

    // reset mid-blink takes effect without a clock edge
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'(instruction), 64'(BLANK_W));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(4'b1101, 0, 0);
    chk("post_rst_err", 64'(instruction), 64'(enc("ERROR   ", 0)));

`ifdef ATM_MSG_SCROLL_EN
    for (int k = 0; k < 40; k++) begin
      cyc(4'b0000, 0, 0);
      chk("scroll", 64'(instruction), 64'(enc(scroll_txt, (k / SDIV) % 16)));
    end
    #2 rst = 1'b1;
    #1 chk("rst_scroll", 64'(instruction), 64'(BLANK_W));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
`endif

    // randomized states and button activity
    u = 0; d = 0;
    for (int seg = 0; seg < 150; seg++) begin
      case ($urandom_range(0, 6))
        0: st = 4'b0000;
        1: st = 4'b0110;
        2: st = 4'b1011;
        3: st = 4'b1101;
        4: st = 4'b1110;
        default: st = 4'($urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 2) == 0) u = ~u;
        if ($urandom_range(0, 2) == 0) d = ~d;
        cyc(st, u, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
